// File: rtl/pkt_stat_sink.sv
// pkt_stat_sink: destination-side packet sink with throttled ready and statistics.
//
// Terminates one arbiter output port. Acceptance is throttled by a 16-bit
// rotating ready pattern loaded on entry to RUN. Each accepted packet adds its
// source-to-sink latency (time - injection timestamp, modulo 2^TS_W) to a
// cumulative sum. Stalled offers (valid with ready low) are counted as delay.
// All counters saturate at 32'hFFFF_FFFF.
//
// Ports:
//   clock           in   sole clock
//   reset           in   asynchronous active-low reset
//   io_enable       in   run control; nothing accepted while low
//   io_dst_pat      in   ready throttle pattern, sampled on entry to RUN
//   io_in_valid     in   packet offered
//   io_in_ready     out  sink accepts this cycle (registered)
//   io_in_dst       in   destination field of the offered packet
//   io_in_ts        in   injection timestamp from the source-side time counter
//   io_cum_latency  out  saturating sum of latencies of accepted packets
//   io_pkt_count    out  saturating count of accepted packets
//   io_cum_delay    out  saturating count of valid-and-not-ready cycles
//   io_addr_error   out  sticky misroute flag
//
// Configuration macro:
//   PKT_STAT_SINK_ADDR_CHECK_EN  when defined, an accepted packet whose
//                                destination differs from ADDR sets
//                                io_addr_error; otherwise the flag is tied 0.

module pkt_stat_sink #(
    parameter int unsigned ADDR  = 0,
    parameter int unsigned DST_W = 3,
    parameter int unsigned TS_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enable,
    input  logic [15:0]      io_dst_pat,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [DST_W-1:0] io_in_dst,
    input  logic [TS_W-1:0]  io_in_ts,
    output logic [31:0]      io_cum_latency,
    output logic [31:0]      io_pkt_count,
    output logic [31:0]      io_cum_delay,
    output logic             io_addr_error
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PAT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ready_q, ready_d;
    logic [TS_W-1:0]    time_q, time_d;
    logic [CNT_W-1:0]   lat_sum_q, lat_sum_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic               addr_err_q, addr_err_d;

    logic               accept;
    logic               stall;
    logic [TS_W-1:0]    latency;

    // Saturating 32-bit add: the carry out of a 33-bit sum pins the result.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Next-state, throttle pattern and statistics update.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        ready_d    = 1'b0;
        time_d     = time_q + TS_W'(1);
        lat_sum_d  = lat_sum_q;
        pkt_cnt_d  = pkt_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        addr_err_d = addr_err_q;

        accept  = io_in_valid & ready_q;
        stall   = io_in_valid & ~ready_q;
        // Modular difference handles timestamps taken before the counter wrapped.
        latency = time_q - io_in_ts;

        case (state_q)
            ST_IDLE: begin
                if (io_enable) begin
                    state_d = ST_RUN;
                    pat_d   = io_dst_pat;
                    ready_d = io_dst_pat[0];
                end
            end
            ST_RUN: begin
                if (io_enable) begin
                    // Rotate right; the bit that lands in pat[0] drives next-cycle ready.
                    pat_d   = {pat_q[0], pat_q[PAT_W-1:1]};
                    ready_d = pat_q[1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            pkt_cnt_d = sat_add(pkt_cnt_q, CNT_W'(1));
            lat_sum_d = sat_add(lat_sum_q, CNT_W'(latency));
        end
        if (stall) begin
            dly_cnt_d = sat_add(dly_cnt_q, CNT_W'(1));
        end

`ifdef PKT_STAT_SINK_ADDR_CHECK_EN
        if (accept && (io_in_dst != DST_W'(ADDR))) begin
            addr_err_d = 1'b1;
        end
`endif
    end

`ifndef PKT_STAT_SINK_ADDR_CHECK_EN
    // Destination field is intentionally ignored without the address check.
    logic unused_dst;
    assign unused_dst = ^io_in_dst;
`endif

    // State and statistics registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            ready_q    <= 1'b0;
            time_q     <= '0;
            lat_sum_q  <= '0;
            pkt_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            ready_q    <= ready_d;
            time_q     <= time_d;
            lat_sum_q  <= lat_sum_d;
            pkt_cnt_q  <= pkt_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign io_in_ready    = ready_q;
    assign io_cum_latency = lat_sum_q;
    assign io_pkt_count   = pkt_cnt_q;
    assign io_cum_delay   = dly_cnt_q;
    assign io_addr_error  = addr_err_q;

endmodule

// File: tb/tb_pkt_stat_sink.sv
// Self-checking bench for pkt_stat_sink: directed scenarios followed by a
// randomized phase, all compared against a cycle-level behavioural model.
module tb_pkt_stat_sink;

    localparam int unsigned ADDR  = 0;
    localparam int unsigned DST_W = 3;
    localparam int unsigned TS_W  = 16;
    localparam longint unsigned SAT = 64'h0000_0000_FFFF_FFFF;
`ifdef PKT_STAT_SINK_ADDR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic [15:0]      pat;
    logic             v;
    logic             rdy;
    logic [DST_W-1:0] dst;
    logic [TS_W-1:0]  ts;
    logic [31:0]      cum_lat, pkt_cnt, cum_dly;
    logic             addr_err;

    pkt_stat_sink #(.ADDR(ADDR), .DST_W(DST_W), .TS_W(TS_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_enable      (en),
        .io_dst_pat     (pat),
        .io_in_valid    (v),
        .io_in_ready    (rdy),
        .io_in_dst      (dst),
        .io_in_ts       (ts),
        .io_cum_latency (cum_lat),
        .io_pkt_count   (pkt_cnt),
        .io_cum_delay   (cum_dly),
        .io_addr_error  (addr_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: run flag, loaded pattern and index of the current RUN cycle.
    bit              m_run;
    logic [15:0]     m_pat;
    int              m_k;
    logic [15:0]     m_time;
    longint unsigned m_cnt, m_lat, m_dly;
    bit              m_err;
    bit              last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_run && m_pat[m_k % 16];
    endfunction

    function automatic longint unsigned sat(input longint unsigned x);
        return (x > SAT) ? SAT : x;
    endfunction

    task automatic model_clear();
        m_run = 0; m_pat = '0; m_k = 0; m_time = '0;
        m_cnt = 0; m_lat = 0; m_dly = 0; m_err = 0; last_acc = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_ready"}, 64'(rdy), 64'(m_ready()));
        check({pfx, "_cnt"}, 64'(pkt_cnt), m_cnt);
        check({pfx, "_lat"}, 64'(cum_lat), m_lat);
        check({pfx, "_dly"}, 64'(cum_dly), m_dly);
        check({pfx, "_err"}, 64'(addr_err), 64'(m_err));
    endtask

    // One clock: predict the edge from the inputs currently driven, then compare.
    task automatic step();
        bit          acc;
        logic [15:0] l;
        acc = v && m_ready();
        last_acc = acc;
        if (acc) begin
            l = m_time - ts;
            m_cnt = sat(m_cnt + 1);
            m_lat = sat(m_lat + 64'(l));
            if (ERR_EN && dst != DST_W'(ADDR)) m_err = 1;
        end else if (v) begin
            m_dly = sat(m_dly + 1);
        end
        if (!m_run && en) begin
            m_run = 1; m_pat = pat; m_k = 0;
        end else if (m_run && en) begin
            m_k++;
        end else if (m_run && !en) begin
            m_run = 0;
        end
        m_time = m_time + 16'd1;
        @(posedge clock);
        #1;
        check_outputs("cyc");
    endtask

    // Asynchronous reset taken between edges; outputs must clear at once.
    task automatic apply_reset();
        #1;
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs("rst");
        v = 0; en = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic new_pkt(input int age);
        v = 1; dst = DST_W'(ADDR); ts = m_time - 16'(age);
    endtask

    longint unsigned base;

    initial begin
        reset = 1'b0; en = 0; pat = '0; v = 0; dst = '0; ts = '0;
        model_clear();
        apply_reset();

        // Full-rate acceptance, latency 2 per packet.
        en = 1; pat = 16'hFFFF; v = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            new_pkt(2);
            step();
        end
        v = 0;
        check("s1_cnt", 64'(pkt_cnt), 64'd10);
        check("s1_lat", 64'(cum_lat), 64'd20);
        check("s1_dly", 64'(cum_dly), 64'd0);

        // Alternating pattern over 16 RUN cycles with a held packet.
        en = 0; step();
        en = 1; pat = 16'h5555; step();
        check("s2_first_rdy", 64'(rdy), 64'd1);
        base = m_cnt;
        begin
            longint unsigned d0;
            d0 = m_dly;
            last_acc = 1;
            for (int i = 0; i < 16; i++) begin
                if (last_acc) new_pkt(3);
                step();
            end
            check("s2_cnt_delta", 64'(pkt_cnt), base + 8);
            check("s2_dly_delta", 64'(cum_dly), d0 + 8);
        end

        // Disabled with valid high, then re-enable reloads the pattern.
        v = 0; en = 0; step();
        base = m_dly;
        new_pkt(1);
        for (int i = 0; i < 5; i++) step();
        check("s3_idle_rdy", 64'(rdy), 64'd0);
        check("s3_dly_delta", 64'(cum_dly), base + 5);
        en = 1; pat = 16'h0006; step();
        check("s3_reload_rdy0", 64'(rdy), 64'd0);
        step();
        check("s3_reload_rdy1", 64'(rdy), 64'd1);
        step();
        check("s3_held_acc", 64'(last_acc), 64'd1);
        v = 0;

        // Misrouted packet sets the sticky flag only with the check enabled.
        en = 0; step();
        en = 1; pat = 16'hFFFF; step();
        v = 1; dst = DST_W'(ADDR + 1); ts = m_time - 16'd4; step();
        v = 0; dst = DST_W'(ADDR);
        check("mis_err", 64'(addr_err), 64'(ERR_EN));
        for (int i = 0; i < 3; i++) step();
        check("mis_err_sticky", 64'(addr_err), 64'(ERR_EN));

        // Reset mid-run after 7 accepts.
        for (int i = 0; i < 7; i++) begin
            new_pkt(i + 1);
            step();
        end
        apply_reset();
        check("mr_cnt0", 64'(pkt_cnt), 64'd0);
        check("mr_err0", 64'(addr_err), 64'd0);

        // Timestamp wrap right after reset: ts FFFE accepted at time 3.
        en = 1; pat = 16'hFFFF; v = 0;
        step(); step(); step();
        v = 1; dst = DST_W'(ADDR); ts = 16'hFFFE;
        check("wrap_time", 64'(m_time), 64'd3);
        step();
        v = 0;
        check("wrap_lat", 64'(cum_lat), 64'd5);
        check("wrap_cnt", 64'(pkt_cnt), 64'd1);

        // Randomized traffic, enable and patterns.
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 15) != 0);
            pat = 16'($urandom);
            if (!(v && !last_acc)) begin
                v = ($urandom_range(0, 2) != 0);
                ts = m_time - 16'($urandom_range(0, 400));
                dst = ($urandom_range(0, 15) == 0) ? DST_W'($urandom) : DST_W'(ADDR);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
